// File: rtl/shift_sequencer_if.sv
// Command/status bundle between a requester and the shift sequencer, plus the
// strobes the sequencer drives into the downstream load/shift-right register.
interface shift_sequencer_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
);
   // command side
   logic             start;
   logic             abort;
   logic [WIDTH-1:0] data_in;
   logic [CNT_W-1:0] shift_amt;
   logic             arith;
   // shifter drive
   logic [WIDTH-1:0] load_val;
   logic             load_n;
   logic             shift_right;
   logic             asr;
   // status
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] shifts_issued;

   modport master (
      output start, abort, data_in, shift_amt, arith,
      input  load_val, load_n, shift_right, asr, busy, done, shifts_issued
   );

   modport slave (
      input  start, abort, data_in, shift_amt, arith,
      output load_val, load_n, shift_right, asr, busy, done, shifts_issued
   );
endinterface

// File: rtl/shift_sequencer.sv
// Turns a one-cycle "load X, shift right N" command into one load strobe and
// N divider-spaced shift pulses for a downstream shift register, then pulses done.
module shift_sequencer #(
   parameter int WIDTH    = 8,
   parameter int CNT_W    = 4,
   parameter int TICK_DIV = 1
) (
   input  logic            clock,
   input  logic            reset_n,
   shift_sequencer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   localparam int             DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] WIDTH_C  = CNT_W'(WIDTH);

   state_t           state, state_nxt;
   logic [DIV_W-1:0] divider;
   logic [CNT_W-1:0] remaining;
   logic [CNT_W-1:0] shifts_issued;
   logic [WIDTH-1:0] load_val;
   logic             asr;
   logic             tick;
   logic             load_n, shift_right, busy, done;

   // one shift step completes when the divider reaches its last count
   assign tick = (state == SHIFT) && (divider == DIV_LAST);

   // state register
   always_ff @(posedge clock) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // next-state: abort only matters while busy; start only while idle
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (bus.start) state_nxt = LOAD;
         LOAD:  if (bus.abort)                 state_nxt = IDLE;
                else if (remaining == '0)      state_nxt = DONE;
                else                           state_nxt = SHIFT;
         SHIFT: if (bus.abort)                 state_nxt = IDLE;
                else if (tick && remaining == CNT_W'(1)) state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // outputs decoded from state/divider only, never from inputs
   always_comb begin
      load_n      = (state != LOAD);
      shift_right = tick;
      busy        = (state == LOAD) || (state == SHIFT);
      done        = (state == DONE);
   end

   // command latch, step divider and shift bookkeeping; a pulse issued in an
   // aborted cycle still reached the shifter, so it is still counted
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         load_val      <= '0;
         asr           <= 1'b0;
         shifts_issued <= '0;
         divider       <= '0;
         remaining     <= '0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               load_val      <= bus.data_in;
               asr           <= bus.arith;
               remaining     <= (bus.shift_amt > WIDTH_C) ? WIDTH_C : bus.shift_amt;
               shifts_issued <= '0;
            end
            LOAD: divider <= '0;
            SHIFT: if (tick) begin
               divider       <= '0;
               remaining     <= remaining - 1'b1;
               shifts_issued <= shifts_issued + 1'b1;
            end else begin
               divider <= divider + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.load_val      = load_val;
   assign bus.asr           = asr;
   assign bus.shifts_issued = shifts_issued;
   assign bus.load_n        = load_n;
   assign bus.shift_right   = shift_right;
   assign bus.busy          = busy;
   assign bus.done          = done;

endmodule
